hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum consecutive dm_busy cycles before a timeout is flagged.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_id  in  5  rs1 address in ID.
- rs2_id  in  5  rs2 address in ID.
- RD_ex  in  5  destination register in EX.
- DMRd_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- dm_busy  in  1  data memory in MEM not ready.
- PCWr  out  1  PC write enable.
- IFIDWr  out  1  IF/ID register write enable.
- IFIDFlush  out  1  IF/ID clear to NOP.
- IDEXFlush  out  1  ID/EX clear to NOP (bubble).
- PipeHold  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky dm_busy timeout error.

Function
REQ-003 SHALL use an FSM with states RUN and MEM_WAIT.
REQ-004 RUN->MEM_WAIT SHALL occur at a clock edge where dm_busy=1. MEM_WAIT->RUN SHALL occur at the first edge where dm_busy=0.
REQ-005 Freeze (dm_busy=1, any state) SHALL drive PCWr=0, IFIDWr=0, PipeHold=1, IFIDFlush=0 and IDEXFlush=0. Outputs are combinational from dm_busy, so there is zero-cycle latency.
REQ-006 When not frozen and branch_taken_ex=1, outputs SHALL be IFIDFlush=1, IDEXFlush=1, PCWr=1, IFIDWr=1 and PipeHold=0.
REQ-007 When not frozen, branch_taken_ex=0, DMRd_ex=1, RD_ex!=0 and (RD_ex==rs1_id or RD_ex==rs2_id): this is a load-use stall. Outputs SHALL be PCWr=0, IFIDWr=0, IDEXFlush=1, IFIDFlush=0 and PipeHold=0, producing exactly one bubble.
REQ-008 Priority SHALL be freeze > branch flush > load-use. A simultaneous branch and load-use resolves as a branch flush with no stall.
REQ-009 Otherwise outputs SHALL be PCWr=1, IFIDWr=1, both flushes 0 and PipeHold=0.
REQ-010 A branch_taken_ex asserted during a freeze SHALL be acted on in the first unfrozen cycle. EX is held, so the input persists and no pending register is required.
REQ-011 An 8-bit wait counter SHALL increment each cycle in MEM_WAIT with dm_busy=1, saturate at 255, and clear on entry to RUN.
REQ-012 When the wait counter reaches TIMEOUT_CYC, mem_timeout SHALL set at the next edge and stay set until rst. The freeze still follows dm_busy.
REQ-013 The register x0 (RD_ex==0) SHALL never cause a stall.

Reset
REQ-014 rst=1 at a clock edge SHALL force state=RUN, wait counter=0, mem_timeout=0 and all performance counters=0. This applies even mid-MEM_WAIT.
REQ-015 While rst=1, the combinational outputs SHALL still follow REQ-005..REQ-009. The surrounding pipeline registers clear themselves.

Configuration
REQ-016 With macro HAZARD_PERF_COUNTERS_EN defined, the block SHALL add three 32-bit wrapping outputs:
- stall_cnt: counts load-use cycles.
- flush_cnt: counts branch-flush cycles.
- freeze_cnt: counts dm_busy cycles.
REQ-017 Each counter SHALL increment at the edge ending its event cycle.
REQ-018 Without HAZARD_PERF_COUNTERS_EN, those ports and registers SHALL be absent, with no other behavioural change.

Structure
REQ-019 Package pipeline_pkg SHALL hold:
- the FSM enum hz_state_t {RUN, MEM_WAIT};
- the constants REG_ADDR_W=5 and REG_ZERO=5'd0.
REQ-020 Performance counters SHALL be instances of sub-module hz_event_counter (32-bit enable counter with synchronous clear).

Verification
REQ-021 The bench SHALL cover these scenarios:
- Load-use: DMRd_ex=1, RD_ex=5, rs1_id=5 for one cycle -> PCWr=0, IFIDWr=0, IDEXFlush=1. The next cycle, with DMRd_ex=0, all return to the REQ-009 values.
- x0 load: DMRd_ex=1, RD_ex=0, rs2_id=0 -> no stall, PCWr=1.
- Branch with load-use: branch_taken_ex=1, plus the load-use condition -> IFIDFlush=1, IDEXFlush=1, PCWr=1.
- Freeze: dm_busy=1 for 4 cycles with branch_taken_ex=1 -> PipeHold=1 and no flush for 4 cycles, then the flush fires in cycle 5. freeze_cnt=4 when HAZARD_PERF_COUNTERS_EN is defined.
- Timeout: TIMEOUT_CYC=3 with dm_busy held 6 cycles -> mem_timeout rises after the 4th busy edge, stays 1 after dm_busy falls, and clears only on rst.
- Reset mid-wait: rst=1 during MEM_WAIT with dm_busy=0 -> next cycle state=RUN, wait counter=0, mem_timeout=0, counters=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int WAIT_CNT_W = 8;
  localparam int PERF_CNT_W = 32;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_t;

  // Pipeline control bundle, field order matches the interface outputs.
  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard sources in, pipeline control out.
interface hazard_control_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic [REG_ADDR_W-1:0] RD_ex;
  logic                  DMRd_ex;
  logic                  branch_taken_ex;
  logic                  dm_busy;
  logic                  PCWr;
  logic                  IFIDWr;
  logic                  IFIDFlush;
  logic                  IDEXFlush;
  logic                  PipeHold;
  logic                  mem_timeout;

  // Pipeline side: presents hazard sources, consumes control.
  modport master (
    output rs1_id, rs2_id, RD_ex, DMRd_ex, branch_taken_ex, dm_busy,
    input  PCWr, IFIDWr, IFIDFlush, IDEXFlush, PipeHold, mem_timeout
  );

  // Hazard unit side.
  modport slave (
    input  rs1_id, rs2_id, RD_ex, DMRd_ex, branch_taken_ex, dm_busy,
    output PCWr, IFIDWr, IFIDFlush, IDEXFlush, PipeHold, mem_timeout
  );

endinterface

// File: rtl/hz_event_counter.sv
// Wrapping event counter with enable and synchronous clear.
module hz_event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: memory freeze, branch flush, load-use stall, busy timeout.
// Optional event counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  hazard_control_if.slave   hz
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] freeze_cnt
`endif
);

  hz_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;

  logic     freeze_ev, flush_ev, stall_ev, load_use;
  hz_ctrl_t ctrl;

  // Event classification; freeze outranks branch, branch outranks load-use.
  always_comb begin
    load_use  = hz.DMRd_ex && (hz.RD_ex != REG_ZERO) &&
                ((hz.RD_ex == hz.rs1_id) || (hz.RD_ex == hz.rs2_id));
    freeze_ev = hz.dm_busy;
    flush_ev  = !freeze_ev && hz.branch_taken_ex;
    stall_ev  = !freeze_ev && !hz.branch_taken_ex && load_use;
  end

  // NOTE: every output gets a default first so no branch can infer a latch.
  always_comb begin
    ctrl = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, pipe_hold: 1'b0};
    if (freeze_ev) begin
      ctrl = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0, pipe_hold: 1'b1};
    end else if (flush_ev) begin
      ctrl = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, pipe_hold: 1'b0};
    end else if (stall_ev) begin
      ctrl = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, pipe_hold: 1'b0};
    end
  end

  // Wait-state FSM with saturating busy counter and sticky timeout.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN:      if (hz.dm_busy)  state_d = MEM_WAIT;
      MEM_WAIT: if (!hz.dm_busy) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if ((state_q == MEM_WAIT) && hz.dm_busy) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
      if ({{(32-WAIT_CNT_W){1'b0}}, wait_cnt_d} >= 32'(TIMEOUT_CYC)) mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz.PCWr        = ctrl.pc_wr;
  assign hz.IFIDWr      = ctrl.ifid_wr;
  assign hz.IFIDFlush   = ctrl.ifid_flush;
  assign hz.IDEXFlush   = ctrl.idex_flush;
  assign hz.PipeHold    = ctrl.pipe_hold;
  assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  hz_event_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk (clk), .clr (rst), .en (stall_ev), .cnt (stall_cnt)
  );
  hz_event_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk (clk), .clr (rst), .en (flush_ev), .cnt (flush_cnt)
  );
  hz_event_counter #(.W(PERF_CNT_W)) u_freeze_cnt (
    .clk (clk), .clr (rst), .en (freeze_ev), .cnt (freeze_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control (TIMEOUT_CYC=3); optional counters under HAZARD_PERF_COUNTERS_EN.
module tb_hazard_control;
  import pipeline_pkg::*;

  // {PCWr, IFIDWr, IFIDFlush, IDEXFlush, PipeHold}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] ctrl;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_if hz_if ();

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [31:0] exp_stall = 0, exp_flush = 0, exp_freeze = 0;
`endif

  hazard_control #(.TIMEOUT_CYC(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .hz         (hz_if)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .freeze_cnt (freeze_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, push expectation, compare on the falling edge.
  task automatic drive(input string tag, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic busy,
                       input logic [4:0] ctrl, input logic tmo);
    exp_t e;
    rst                   = r;
    hz_if.rs1_id          = rs1;
    hz_if.rs2_id          = rs2;
    hz_if.RD_ex           = rd;
    hz_if.DMRd_ex         = ld;
    hz_if.branch_taken_ex = br;
    hz_if.dm_busy         = busy;
    e.tag  = tag;
    e.ctrl = ctrl;
    e.tmo  = tmo;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, "/ctrl"},
          {27'd0, hz_if.PCWr, hz_if.IFIDWr, hz_if.IFIDFlush, hz_if.IDEXFlush, hz_if.PipeHold},
          {27'd0, e.ctrl});
    check({e.tag, "/timeout"}, {31'd0, hz_if.mem_timeout}, {31'd0, e.tmo});
`ifdef HAZARD_PERF_COUNTERS_EN
    check({e.tag, "/stall_cnt"},  stall_cnt,  exp_stall);
    check({e.tag, "/flush_cnt"},  flush_cnt,  exp_flush);
    check({e.tag, "/freeze_cnt"}, freeze_cnt, exp_freeze);
    if (r) begin
      exp_stall = 0; exp_flush = 0; exp_freeze = 0;
    end else if (busy) begin
      exp_freeze++;
    end else if (e.ctrl == O_FLUSH) begin
      exp_flush++;
    end else if (e.ctrl == O_STALL) begin
      exp_stall++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    hz_if.rs1_id = '0; hz_if.rs2_id = '0; hz_if.RD_ex = '0;
    hz_if.DMRd_ex = 1'b0; hz_if.branch_taken_ex = 1'b0; hz_if.dm_busy = 1'b0;
    @(posedge clk);
    #1;

    //     tag             rst rs1 rs2 rd  ld br bsy  ctrl      tmo
    drive("reset",         1,  0,  0,  0,  0, 0, 0,   O_RUN,    0);
    drive("idle",          0,  1,  2,  3,  0, 0, 0,   O_RUN,    0);
    drive("load_use_rs1",  0,  5,  0,  5,  1, 0, 0,   O_STALL,  0);
    drive("after_stall",   0,  5,  0,  5,  0, 0, 0,   O_RUN,    0);
    drive("load_use_rs2",  0,  1,  7,  7,  1, 0, 0,   O_STALL,  0);
    drive("load_no_dep",   0,  1,  2,  3,  1, 0, 0,   O_RUN,    0);
    drive("x0_load",       0,  4,  0,  0,  1, 0, 0,   O_RUN,    0);
    drive("x0_both",       0,  0,  0,  0,  1, 0, 0,   O_RUN,    0);
    drive("branch",        0,  1,  2,  3,  0, 1, 0,   O_FLUSH,  0);
    drive("branch_lu",     0,  5,  0,  5,  1, 1, 0,   O_FLUSH,  0);
    drive("alu_dep",       0,  5,  0,  5,  0, 0, 0,   O_RUN,    0);

    // Four-cycle freeze holding a branch and a load-use; flush fires when released.
    for (int i = 0; i < 4; i++)
      drive("freeze",      0,  5,  0,  5,  1, 1, 1,   O_FREEZE, 0);
    drive("freeze_exit",   0,  5,  0,  5,  1, 1, 0,   O_FLUSH,  1);
    drive("rst_clear",     1,  0,  0,  0,  0, 0, 0,   O_RUN,    1);
    drive("post_rst",      0,  0,  0,  0,  0, 0, 0,   O_RUN,    0);

    // Three busy cycles stay under the limit; the gap must clear the wait counter.
    for (int i = 0; i < 3; i++)
      drive("busy3a",      0,  0,  0,  0,  0, 0, 1,   O_FREEZE, 0);
    drive("gap",           0,  0,  0,  0,  0, 0, 0,   O_RUN,    0);
    for (int i = 0; i < 3; i++)
      drive("busy3b",      0,  0,  0,  0,  0, 0, 1,   O_FREEZE, 0);
    drive("gap2",          0,  0,  0,  0,  0, 0, 0,   O_RUN,    0);

    // Six busy cycles: timeout visible from the fifth cycle, then sticky.
    for (int i = 0; i < 6; i++)
      drive("timeout",     0,  0,  0,  0,  0, 0, 1,   O_FREEZE, (i >= 4) ? 1'b1 : 1'b0);
    drive("tmo_sticky",    0,  0,  0,  0,  0, 0, 0,   O_RUN,    1);
    drive("tmo_sticky2",   0,  5,  0,  5,  1, 0, 0,   O_STALL,  1);

    // Reset in the middle of a wait.
    for (int i = 0; i < 2; i++)
      drive("wait_pre",    0,  0,  0,  0,  0, 0, 1,   O_FREEZE, 1);
    drive("rst_midwait",   1,  0,  0,  0,  0, 0, 0,   O_RUN,    1);
    check("midwait/state",    32'(dut.state_q), 32'(RUN));
    check("midwait/wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    drive("post_rst2",     0,  0,  0,  0,  0, 0, 0,   O_RUN,    0);

    // Reset while still busy: outputs keep freezing, state still forced to RUN.
    for (int i = 0; i < 3; i++)
      drive("wait_pre2",   0,  0,  0,  0,  0, 0, 1,   O_FREEZE, 0);
    drive("rst_busy",      1,  5,  0,  5,  1, 1, 1,   O_FREEZE, 0);
    check("rst_busy/state",    32'(dut.state_q), 32'(RUN));
    check("rst_busy/wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    drive("post_rst3",     0,  0,  0,  0,  0, 0, 0,   O_RUN,    0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
